hazard_stall_ctrl: RTL and testbench

Pipeline hazard controller that sequences the fetch stage for the 5-stage CPU. It detects load-use and multiply/divide-busy hazards in ID and drives the PC hold, IF/ID hold/flush and ID/EX bubble controls. It also gates taken-branch redirects so the PC never advances past a stalled instruction. It sits between the ID/EX/MEM pipeline registers and the PC / IF-ID register enables.

---
 rtl/hazard_pkg.sv | 18 +
 rtl/md_busy_timer.sv | 28 ++
 rtl/hazard_stall_ctrl.sv | 107 ++++++++++
 tb/tb_hazard_stall_ctrl.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package hazard_pkg;

    localparam int CNT_W = 4;
    localparam logic [4:0] REG_ZERO = 5'd0;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        STALL_LU = 2'd1,
        STALL_MD = 2'd2
    } state_t;

    localparam logic [1:0] CAUSE_NONE = 2'b00;
    localparam logic [1:0] CAUSE_LU   = 2'b01;
    localparam logic [1:0] CAUSE_MD   = 2'b10;
    localparam logic [1:0] CAUSE_BOTH = 2'b11;

endpackage

// File: rtl/md_busy_timer.sv
// Mult/div busy down-counter: start loads LOAD_VAL, then counts down to 0 and holds there.
module md_busy_timer
    import hazard_pkg::*;
#(
    parameter logic [CNT_W-1:0] LOAD_VAL = CNT_W'(5)
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    output logic busy
);

    logic [CNT_W-1:0] cnt;

    // A start while already busy restarts the full latency rather than adding to it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (start) begin
            cnt <= LOAD_VAL;
        end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign busy = (cnt != '0);

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Load-use / mult-div hazard detection, stall and redirect gating for the 5-stage pipeline.
// Define HAZARD_MD_EN to compile in the mult/div busy timer and its stall path.
//
// state    | meaning
// RUN      | no hazard seen last cycle
// STALL_LU | last cycle stalled on a load-use hazard
// STALL_MD | last cycle stalled on a busy mult/div unit
module hazard_stall_ctrl
    import hazard_pkg::*;
#(
    parameter int MD_LAT = 5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] id_rs,
    input  logic [4:0] id_rt,
    input  logic       id_uses_rs,
    input  logic       id_uses_rt,
    input  logic       id_is_md,
    input  logic       id_branch_taken,
    input  logic [4:0] ex_rd,
    input  logic       ex_is_load,
    input  logic       md_start,
    output logic       pc_hold,
    output logic       ifid_hold,
    output logic       idex_flush,
    output logic       ifid_flush,
    output logic       redirect_ok,
    output logic       md_busy,
    output logic [1:0] stall_cause,
    output state_t     state
);

    logic   load_use;
    logic   md_hz;
    logic   stall;
    state_t state_nxt;

    assign load_use = ex_is_load && (ex_rd != REG_ZERO) &&
                      ((id_uses_rs && (id_rs == ex_rd)) ||
                       (id_uses_rt && (id_rt == ex_rd)));

`ifdef HAZARD_MD_EN
    md_busy_timer #(
        .LOAD_VAL(CNT_W'(MD_LAT))
    ) u_md_busy_timer (
        .clk   (clk),
        .reset (reset),
        .start (md_start),
        .busy  (md_busy)
    );

    assign md_hz = id_is_md && md_busy;
`else
    logic unused_md;
    assign unused_md = ^{md_start, id_is_md, MD_LAT[0]};
    assign md_busy   = 1'b0;
    assign md_hz     = 1'b0;
`endif

    assign stall = load_use || md_hz;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= RUN;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = RUN;
        if (md_hz) begin
            state_nxt = STALL_MD;
        end else if (load_use) begin
            state_nxt = STALL_LU;
        end
    end

    // A stall suppresses any redirect; the branch re-resolves once ID is released.
    always_comb begin
        pc_hold     = 1'b0;
        ifid_hold   = 1'b0;
        idex_flush  = 1'b0;
        ifid_flush  = 1'b0;
        redirect_ok = 1'b0;
        if (stall) begin
            pc_hold    = 1'b1;
            ifid_hold  = 1'b1;
            idex_flush = 1'b1;
        end else if (id_branch_taken) begin
            ifid_flush  = 1'b1;
            redirect_ok = 1'b1;
        end

        if (md_hz && load_use) begin
            stall_cause = CAUSE_BOTH;
        end else if (md_hz) begin
            stall_cause = CAUSE_MD;
        end else if (load_use) begin
            stall_cause = CAUSE_LU;
        end else begin
            stall_cause = CAUSE_NONE;
        end
    end

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed-vector bench for hazard_stall_ctrl; expectations follow the HAZARD_MD_EN build setting.
module tb_hazard_stall_ctrl;
    import hazard_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] id_rs, id_rt, ex_rd;
    logic       id_uses_rs, id_uses_rt, id_is_md, id_branch_taken;
    logic       ex_is_load, md_start;
    logic       pc_hold, ifid_hold, idex_flush, ifid_flush, redirect_ok, md_busy;
    logic [1:0] stall_cause;
    state_t     state;

    int n_checks = 0;
    int n_fail   = 0;

`ifdef HAZARD_MD_EN
    localparam bit MD_ON = 1'b1;
`else
    localparam bit MD_ON = 1'b0;
`endif

    hazard_stall_ctrl #(.MD_LAT(5)) dut (
        .clk             (clk),
        .reset           (reset),
        .id_rs           (id_rs),
        .id_rt           (id_rt),
        .id_uses_rs      (id_uses_rs),
        .id_uses_rt      (id_uses_rt),
        .id_is_md        (id_is_md),
        .id_branch_taken (id_branch_taken),
        .ex_rd           (ex_rd),
        .ex_is_load      (ex_is_load),
        .md_start        (md_start),
        .pc_hold         (pc_hold),
        .ifid_hold       (ifid_hold),
        .idex_flush      (idex_flush),
        .ifid_flush      (ifid_flush),
        .redirect_ok     (redirect_ok),
        .md_busy         (md_busy),
        .stall_cause     (stall_cause),
        .state           (state)
    );

    always #5 clk = ~clk;

    // ctl = {pc_hold, ifid_hold, idex_flush, ifid_flush, redirect_ok}
    wire [4:0] ctl = {pc_hold, ifid_hold, idex_flush, ifid_flush, redirect_ok};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        id_rs = 5'd0; id_rt = 5'd0; ex_rd = 5'd0;
        id_uses_rs = 1'b0; id_uses_rt = 1'b0; id_is_md = 1'b0;
        id_branch_taken = 1'b0; ex_is_load = 1'b0; md_start = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        clear_inputs();
        #3;
        n_checks++;
        if (ctl !== 5'b00000 || md_busy !== 1'b0 || stall_cause !== 2'b00) begin
            n_fail++;
            $display("FAIL reset_outputs: got ctl=%b busy=%b cause=%b want 00000/0/00", ctl, md_busy, stall_cause);
        end
        n_checks++;
        if (state !== RUN) begin
            n_fail++;
            $display("FAIL reset_state: got %0d want %0d", state, RUN);
        end
        tick();
        reset = 1'b0;
        tick();
    endtask

    task automatic test_load_use();
        ex_is_load = 1'b1; ex_rd = 5'd8; id_rs = 5'd8; id_uses_rs = 1'b1;
        #1;
        n_checks++;
        if (ctl !== 5'b11100 || stall_cause !== CAUSE_LU) begin
            n_fail++;
            $display("FAIL lu_stall: got ctl=%b cause=%b want 11100/01", ctl, stall_cause);
        end
        tick();
        n_checks++;
        if (state !== STALL_LU) begin
            n_fail++;
            $display("FAIL lu_state: got %0d want %0d", state, STALL_LU);
        end
        // bubble now in EX, load moved on to MEM
        ex_is_load = 1'b0; ex_rd = 5'd0;
        #1;
        n_checks++;
        if (ctl !== 5'b00000 || stall_cause !== CAUSE_NONE) begin
            n_fail++;
            $display("FAIL lu_release: got ctl=%b cause=%b want 00000/00", ctl, stall_cause);
        end
        tick();
        n_checks++;
        if (state !== RUN) begin
            n_fail++;
            $display("FAIL lu_state_back: got %0d want %0d", state, RUN);
        end
        ex_is_load = 1'b1; ex_rd = 5'd0; id_rs = 5'd0; id_uses_rs = 1'b1;
        #1;
        n_checks++;
        if (ctl !== 5'b00000 || stall_cause !== CAUSE_NONE) begin
            n_fail++;
            $display("FAIL lu_rd_zero: got ctl=%b cause=%b want 00000/00", ctl, stall_cause);
        end
        clear_inputs();
        tick();
    endtask

    task automatic test_unused_operand();
        ex_is_load = 1'b1; ex_rd = 5'd9; id_rt = 5'd9; id_uses_rt = 1'b0;
        id_rs = 5'd3; id_uses_rs = 1'b1;
        #1;
        n_checks++;
        if (ctl !== 5'b00000) begin
            n_fail++;
            $display("FAIL rt_unused: got ctl=%b want 00000", ctl);
        end
        id_uses_rt = 1'b1;
        #1;
        n_checks++;
        if (ctl !== 5'b11100 || stall_cause !== CAUSE_LU) begin
            n_fail++;
            $display("FAIL rt_used: got ctl=%b cause=%b want 11100/01", ctl, stall_cause);
        end
        ex_is_load = 1'b0;
        #1;
        n_checks++;
        if (ctl !== 5'b00000) begin
            n_fail++;
            $display("FAIL not_load: got ctl=%b want 00000", ctl);
        end
        clear_inputs();
        tick();
    endtask

    task automatic test_stall_branch();
        ex_is_load = 1'b1; ex_rd = 5'd12; id_rt = 5'd12; id_uses_rt = 1'b1;
        id_branch_taken = 1'b1;
        #1;
        n_checks++;
        if (ctl !== 5'b11100) begin
            n_fail++;
            $display("FAIL br_during_stall: got ctl=%b want 11100", ctl);
        end
        tick();
        ex_is_load = 1'b0;
        #1;
        n_checks++;
        if (ctl !== 5'b00011) begin
            n_fail++;
            $display("FAIL br_after_stall: got ctl=%b want 00011", ctl);
        end
        clear_inputs();
        tick();
    endtask

    task automatic test_md_busy();
        logic [1:0] want_cause;
        logic [4:0] want_ctl;
        id_is_md = 1'b1; md_start = 1'b1;
        #1;
        n_checks++;
        if (md_busy !== 1'b0 || ctl !== 5'b00000) begin
            n_fail++;
            $display("FAIL md_pre_start: got busy=%b ctl=%b want 0/00000", md_busy, ctl);
        end
        tick();
        md_start = 1'b0;
        want_cause = MD_ON ? CAUSE_MD : CAUSE_NONE;
        want_ctl   = MD_ON ? 5'b11100 : 5'b00000;
        for (int k = 0; k < 5; k++) begin
            n_checks++;
            if (md_busy !== MD_ON || ctl !== want_ctl || stall_cause !== want_cause) begin
                n_fail++;
                $display("FAIL md_busy_cyc%0d: got busy=%b ctl=%b cause=%b want %b/%b/%b",
                         k, md_busy, ctl, stall_cause, MD_ON, want_ctl, want_cause);
            end
            tick();
            n_checks++;
            if (state !== (MD_ON ? STALL_MD : RUN)) begin
                n_fail++;
                $display("FAIL md_state_cyc%0d: got %0d", k, state);
            end
        end
        n_checks++;
        if (md_busy !== 1'b0 || ctl !== 5'b00000 || stall_cause !== CAUSE_NONE) begin
            n_fail++;
            $display("FAIL md_release: got busy=%b ctl=%b cause=%b want 0/00000/00", md_busy, ctl, stall_cause);
        end
        clear_inputs();
        tick();
    endtask

    task automatic test_md_restart();
        int busy_cycles;
        md_start = 1'b1;
        tick();
        md_start = 1'b0;
        tick();
        md_start = 1'b1;
        tick();
        md_start = 1'b0;
        id_is_md = 1'b1;
        ex_is_load = 1'b1; ex_rd = 5'd4; id_rs = 5'd4; id_uses_rs = 1'b1;
        #1;
        n_checks++;
        if (stall_cause !== (MD_ON ? CAUSE_BOTH : CAUSE_LU) || ctl !== 5'b11100) begin
            n_fail++;
            $display("FAIL md_both_cause: got cause=%b ctl=%b want %b/11100",
                     stall_cause, ctl, MD_ON ? CAUSE_BOTH : CAUSE_LU);
        end
        ex_is_load = 1'b0;
        busy_cycles = 0;
        for (int k = 0; k < 8; k++) begin
            if (md_busy === 1'b1) busy_cycles++;
            tick();
        end
        n_checks++;
        if (busy_cycles != (MD_ON ? 5 : 0)) begin
            n_fail++;
            $display("FAIL md_restart_len: got %0d busy cycles want %0d", busy_cycles, MD_ON ? 5 : 0);
        end
        clear_inputs();
        tick();
    endtask

    task automatic test_reset_mid();
        md_start = 1'b1;
        tick();
        md_start = 1'b0;
        id_is_md = 1'b1;
        tick();
        tick();
        n_checks++;
        if (md_busy !== MD_ON || state !== (MD_ON ? STALL_MD : RUN)) begin
            n_fail++;
            $display("FAIL rst_mid_pre: got busy=%b state=%0d want %b", md_busy, state, MD_ON);
        end
        #2;
        reset = 1'b1;
        #1;
        n_checks++;
        if (md_busy !== 1'b0 || ctl !== 5'b00000 || stall_cause !== CAUSE_NONE || state !== RUN) begin
            n_fail++;
            $display("FAIL rst_mid_async: got busy=%b ctl=%b cause=%b state=%0d want 0/00000/00/RUN",
                     md_busy, ctl, stall_cause, state);
        end
        tick();
        reset = 1'b0;
        tick();
        n_checks++;
        if (state !== RUN || md_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_mid_after: got state=%0d busy=%b want RUN/0", state, md_busy);
        end
        clear_inputs();
        tick();
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_unused_operand();
        test_stall_branch();
        test_md_busy();
        test_md_restart();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
